opb_register_bank_ppc2simulink: RTL and testbench
=================================================

// Module: opb_register_bank_ppc2simulink
// PURPOSE
//  OPB slave exposing N_REGS 32-bit software registers to user fabric logic, replacing one-wrapper-per-register.
//  Each register is control (PPC write, user read), status (user write, PPC read-only) or pulse (self-clearing).
//  Byte-enable writes, full readback, per-register one-cycle load strobe. Single clock domain: the OPB clock drives user logic.
// PARAMETERS
//  C_BASEADDR     32'h01003800  first byte address of the window (aligned to window size)
//  C_HIGHADDR     32'h010038FF  last byte address of the window
//  N_REGS         8             number of 32-bit registers, 1..64; reg k at C_BASEADDR+4*k
//  STATUS_MASK    0             bit k=1: reg k is status (reads user_data_in word k, writes ignored)
//  AUTOCLR_MASK   0             bit k=1: reg k self-clears to 0 one cycle after being written
//  RESET_VAL      32'h0         reset value of every control register
// PORTS
//  OPB_Clk        in   1           OPB/user clock
//  OPB_Rst_n      in   1           synchronous reset, active-low
//  OPB_ABus       in   [0:31]      address
//  OPB_BE         in   [0:3]       byte enables, BE[0] -> DBus[0:7]
//  OPB_DBus       in   [0:31]      write data
//  OPB_RNW        in   1           1=read, 0=write
//  OPB_select     in   1           transaction valid
//  OPB_seqAddr    in   1           ignored (single-beat only)
//  Sl_DBus        out  [0:31]      read data, 0 when not acking
//  Sl_xferAck     out  1           transfer acknowledge
//  Sl_errAck      out  1           tied 0
//  Sl_retry       out  1           tied 0
//  Sl_toutSup     out  1           tied 0
//  user_data_out  out  N_REGS*32   register k on [32k+31:32k]
//  user_data_in   in   N_REGS*32   status word k on [32k+31:32k]
//  user_load      out  N_REGS      bit k pulses 1 cycle when reg k written
// BEHAVIOUR
//  - Bit order: user bit 31-i == OPB bit i (OPB bit 0 is MSB); byte lane BE[j] covers user bits [31-8j:24-8j].
//  - Hit: OPB_select=1 and C_BASEADDR<=OPB_ABus<=C_HIGHADDR; idx=(OPB_ABus-C_BASEADDR)>>2. No hit -> no response.
//  - FSM IDLE/ACK. IDLE: hit registers addr/RNW/BE/data, -> ACK. ACK: Sl_xferAck=1 one cycle, -> IDLE unconditionally.
//    Select still high in ACK is not re-sampled; max one transfer per 2 cycles; latency select->ack = 1 cycle.
//  - Write (commit on ACK cycle edge): control reg: bytes with BE=1 updated, others kept; user_data_out updates
//    the cycle after ack; user_load[idx]=1 for exactly that cycle. Status reg: data dropped, still acked, no load.
//  - Read: Sl_DBus = reg idx (control/pulse) or user_data_in idx sampled in IDLE hit cycle (status); BE ignored.
//  - idx>=N_REGS inside window: acked, read returns 0, write dropped, no load.
//  - Pulse reg (AUTOCLR): user_data_out word = written value for 1 cycle (coincident with user_load), then 0;
//    reads return current (normally 0). Back-to-back writes -> two separate 1-cycle pulses.
//  - Sl_DBus, Sl_xferAck 0 whenever not in ACK (wired-OR bus).
//  - Reset (OPB_Rst_n=0 at edge): FSM->IDLE, Sl_xferAck=0, Sl_DBus=0, user_load=0, control regs=RESET_VAL,
//    pulse regs=0. Reset during ACK aborts the transfer: no ack, no write, no load.
//  - N_REGS*4 > window size is a configuration error (elaboration-time check).
// TESTING
//  - Reset: hold OPB_Rst_n=0 3 cycles -> all user_data_out=0, user_load=0, Sl_xferAck=0; release, no spurious ack.
//  - Write 32'hDEADBEEF to 0x01003804, BE=4'b1111 -> ack at T+1, word1=DEADBEEF and user_load=8'h02 at T+2; read back DEADBEEF.
//  - Write 32'h11223344 to reg1 with BE=4'b0101 -> word1=DE22BE44; other words unchanged.
//  - STATUS_MASK=8'h04, user_data_in word2=32'hCAFE0001: read 0x01003808 -> CAFE0001; write there -> acked, no change, no load.
//  - AUTOCLR_MASK=8'h01: write 5 to reg0 -> word0=5 one cycle with user_load[0]=1, then 0; select held 4 cycles -> exactly 2 acks.
//  - Read 0x010038F0 (idx 60 >= N_REGS) -> ack, Sl_DBus=0; addr 0x01003900 -> no ack; reset asserted in ACK cycle -> no write.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink_if.sv
`default_nettype none
// ============================================================================
// opb_register_bank_ppc2simulink_if : OPB single-beat slave bus bundle
// Rev 1.0
// ============================================================================
interface opb_register_bank_ppc2simulink_if;
    logic [0:31] ABus;
    logic [0:3]  BE;
    logic [0:31] DBus;
    logic        RNW;
    logic        select;
    logic        seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output ABus, BE, DBus, RNW, select, seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  ABus, BE, DBus, RNW, select, seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface
`default_nettype wire

// File: rtl/opb_register_bank_ppc2simulink.sv
`default_nettype none
// ============================================================================
// opb_register_bank_ppc2simulink : OPB slave with control/status/pulse regs
// Rev 1.0
// ============================================================================
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01003800,
    parameter logic [31:0] C_HIGHADDR   = 32'h010038FF,
    parameter int          N_REGS       = 8,
    parameter logic [63:0] STATUS_MASK  = '0,
    parameter logic [63:0] AUTOCLR_MASK = '0,
    parameter logic [31:0] RESET_VAL    = '0
) (
    input  wire logic                     OPB_Clk,
    input  wire logic                     OPB_Rst_n,
    opb_register_bank_ppc2simulink_if.slave opb,
    output logic [N_REGS*32-1:0]          user_data_out,
    input  wire logic [N_REGS*32-1:0]     user_data_in,
    output logic [N_REGS-1:0]             user_load
);

    if (N_REGS < 1 || N_REGS > 64 ||
        N_REGS * 4 > int'(C_HIGHADDR - C_BASEADDR) + 1) begin : g_cfg_error
        $error("opb_register_bank_ppc2simulink: N_REGS does not fit the address window");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t      state;
    logic [31:0] regs [N_REGS];
    logic [31:0] addr;
    logic [31:0] offset;
    logic [29:0] word_idx;
    logic [3:0]  lanes;
    logic        hit;
    logic [31:0] rd_word;

    logic [29:0] cap_idx;
    logic        cap_rnw;
    logic [3:0]  cap_be;
    logic [31:0] cap_data;
    logic        ack;
    logic [31:0] rdata;

    // Declaring the OPB vectors [0:31] and copying into [31:0] makes OPB bit 0 user bit 31.
    assign addr     = opb.ABus;
    assign lanes    = opb.BE;
    assign hit      = opb.select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign offset   = addr - C_BASEADDR;
    assign word_idx = offset[31:2];

    // Indices past N_REGS fall through the loop and read as zero.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (word_idx == 30'(k)) begin
                rd_word = STATUS_MASK[k] ? user_data_in[32*k +: 32] : regs[k];
            end
        end
    end

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state     <= IDLE;
            ack       <= 1'b0;
            rdata     <= '0;
            user_load <= '0;
            cap_idx   <= '0;
            cap_rnw   <= 1'b0;
            cap_be    <= '0;
            cap_data  <= '0;
            for (int k = 0; k < N_REGS; k++) begin
                regs[k] <= (STATUS_MASK[k] || AUTOCLR_MASK[k]) ? 32'h0 : RESET_VAL;
            end
        end else begin
            user_load <= '0;
            for (int k = 0; k < N_REGS; k++) begin
                if (AUTOCLR_MASK[k]) regs[k] <= '0;
            end
            case (state)
                IDLE: begin
                    if (hit) begin
                        state    <= ACK;
                        ack      <= 1'b1;
                        rdata    <= opb.RNW ? rd_word : 32'h0;
                        cap_idx  <= word_idx;
                        cap_rnw  <= opb.RNW;
                        cap_be   <= lanes;
                        cap_data <= opb.DBus;
                    end
                end
                ACK: begin
                    // Select is not re-sampled here, which caps throughput at one beat per two cycles.
                    state <= IDLE;
                    ack   <= 1'b0;
                    rdata <= '0;
                    if (!cap_rnw) begin
                        for (int k = 0; k < N_REGS; k++) begin
                            if (cap_idx == 30'(k) && !STATUS_MASK[k]) begin
                                regs[k]      <= merge_bytes(regs[k], cap_data, cap_be);
                                user_load[k] <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_REGS; k++) begin : g_out
        assign user_data_out[32*k +: 32] = regs[k];
    end

    assign opb.Sl_DBus    = rdata;
    assign opb.Sl_xferAck = ack;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{opb.seqAddr, offset[1:0], user_data_in};

endmodule
`default_nettype wire

// File: tb/tb_opb_register_bank_ppc2simulink.sv
`default_nettype none
// ============================================================================
// tb_opb_register_bank_ppc2simulink : vector table, hand sequences, random vs model
// Rev 1.0
// ============================================================================
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE    = 32'h01003800;
    localparam logic [31:0] HIGH    = 32'h010038FF;
    localparam logic [7:0]  STATUS  = 8'h04;
    localparam logic [7:0]  AUTOCLR = 8'h01;

    logic         clk;
    logic         rst_n;
    logic [255:0] user_data_out;
    logic [255:0] user_data_in;
    logic [7:0]   user_load;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [8];

    opb_register_bank_ppc2simulink_if bus();

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR  (BASE),
        .C_HIGHADDR  (HIGH),
        .N_REGS      (8),
        .STATUS_MASK (64'h04),
        .AUTOCLR_MASK(64'h01),
        .RESET_VAL   (32'h0)
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .opb          (bus),
        .user_data_out(user_data_out),
        .user_data_in (user_data_in),
        .user_load    (user_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: spec rules applied to an array of words.
    task automatic model(input bit rnw, input logic [31:0] a, input logic [0:3] be,
                         input logic [31:0] d, output bit eack, output logic [31:0] erd,
                         output logic [7:0] eld, output logic [255:0] eout);
        int          idx;
        logic [31:0] m;
        idx  = 0;
        m    = '0;
        eack = (a >= BASE) && (a <= HIGH);
        erd  = '0;
        eld  = '0;
        if (eack) begin
            idx = int'((a - BASE) >> 2);
            if (idx < 8) begin
                if (rnw) begin
                    erd = STATUS[idx] ? user_data_in[32*idx +: 32] : mdl[idx];
                end else if (!STATUS[idx]) begin
                    for (int j = 0; j < 4; j++) if (be[j]) m[31-8*j -: 8] = 8'hFF;
                    mdl[idx] = (mdl[idx] & ~m) | (d & m);
                    eld = 8'(1) << idx;
                end
            end
        end
        for (int k = 0; k < 8; k++) eout[32*k +: 32] = mdl[k];
        for (int k = 0; k < 8; k++) if (AUTOCLR[k]) mdl[k] = '0;
    endtask

    task automatic xfer(input bit rnw, input logic [31:0] a, input logic [0:3] be,
                        input logic [31:0] d, output bit ack, output logic [31:0] rd,
                        output logic [7:0] ld, output logic [255:0] out);
        @(negedge clk);
        bus.select = 1'b1;
        bus.RNW    = rnw;
        bus.ABus   = a;
        bus.BE     = be;
        bus.DBus   = d;
        @(posedge clk); #1;
        ack        = bus.Sl_xferAck;
        rd         = bus.Sl_DBus;
        bus.select = 1'b0;
        @(posedge clk); #1;
        ld  = user_load;
        out = user_data_out;
    endtask

    typedef struct {
        string       name;
        bit          rnw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        bit          ack;
        logic [31:0] rd;
        logic [7:0]  ld;
    } vec_t;

    vec_t tbl [13];

    initial begin
        bit           a_ack, e_ack;
        logic [31:0]  a_rd, e_rd;
        logic [7:0]   a_ld, e_ld;
        logic [255:0] a_out, e_out;
        int           nack, nload, npulse;
        logic [31:0]  ra;
        int           sel;

        tbl[0]  = '{"wr_full",      1'b0, 32'h01003804, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0,        8'h02};
        tbl[1]  = '{"rd_full",      1'b1, 32'h01003804, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF, 8'h00};
        tbl[2]  = '{"wr_be0101",    1'b0, 32'h01003804, 4'b0101, 32'h11223344, 1'b1, 32'h0,        8'h02};
        tbl[3]  = '{"rd_be0101",    1'b1, 32'h01003804, 4'b0000, 32'h0,        1'b1, 32'hDE22BE44, 8'h00};
        tbl[4]  = '{"rd_status",    1'b1, 32'h01003808, 4'b1111, 32'h0,        1'b1, 32'hCAFE0001, 8'h00};
        tbl[5]  = '{"wr_status",    1'b0, 32'h01003808, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h0,        8'h00};
        tbl[6]  = '{"rd_status2",   1'b1, 32'h01003808, 4'b1111, 32'h0,        1'b1, 32'hCAFE0001, 8'h00};
        tbl[7]  = '{"rd_idx60",     1'b1, 32'h010038F0, 4'b1111, 32'h0,        1'b1, 32'h0,        8'h00};
        tbl[8]  = '{"wr_idx60",     1'b0, 32'h010038F0, 4'b1111, 32'h12345678, 1'b1, 32'h0,        8'h00};
        tbl[9]  = '{"rd_above_win", 1'b1, 32'h01003900, 4'b1111, 32'h0,        1'b0, 32'h0,        8'h00};
        tbl[10] = '{"wr_below_win", 1'b0, 32'h010037FC, 4'b1111, 32'h87654321, 1'b0, 32'h0,        8'h00};
        tbl[11] = '{"wr_lane0",     1'b0, 32'h0100381C, 4'b1000, 32'hA5A5A5A5, 1'b1, 32'h0,        8'h80};
        tbl[12] = '{"rd_lane0",     1'b1, 32'h0100381C, 4'b1111, 32'h0,        1'b1, 32'hA5000000, 8'h00};

        for (int k = 0; k < 8; k++) mdl[k] = '0;
        bus.select  = 1'b0;
        bus.RNW     = 1'b1;
        bus.ABus    = '0;
        bus.BE      = '0;
        bus.DBus    = '0;
        bus.seqAddr = 1'b0;
        user_data_in = {8{32'h5A5A0000}};
        user_data_in[64 +: 32] = 32'hCAFE0001;

        // Reset held three cycles
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_out",  user_data_out, '0);
            check("rst_load", 256'(user_load), '0);
            check("rst_ack",  256'(bus.Sl_xferAck), '0);
            check("rst_dbus", 256'(bus.Sl_DBus), '0);
        end
        check("tie_offs", 256'({bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}), '0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_ack", 256'(bus.Sl_xferAck), '0);
        end

        for (int i = 0; i < 13; i++) begin
            model(tbl[i].rnw, tbl[i].addr, tbl[i].be, tbl[i].data, e_ack, e_rd, e_ld, e_out);
            xfer(tbl[i].rnw, tbl[i].addr, tbl[i].be, tbl[i].data, a_ack, a_rd, a_ld, a_out);
            check({tbl[i].name, "_ack"}, 256'(a_ack), 256'(tbl[i].ack));
            if (tbl[i].rnw) check({tbl[i].name, "_rd"}, 256'(a_rd), 256'(tbl[i].rd));
            check({tbl[i].name, "_load"}, 256'(a_ld), 256'(tbl[i].ld));
            check({tbl[i].name, "_out"}, a_out, e_out);
        end

        // Pulse register: value for one cycle alongside load, then zero
        xfer(1'b0, BASE, 4'b1111, 32'h5, a_ack, a_rd, a_ld, a_out);
        check("pulse_ack",  256'(a_ack), 256'(1));
        check("pulse_load", 256'(a_ld), 256'(8'h01));
        check("pulse_val",  256'(a_out[31:0]), 256'(32'h5));
        @(posedge clk); #1;
        check("pulse_clr_val",  256'(user_data_out[31:0]), '0);
        check("pulse_clr_load", 256'(user_load), '0);

        // Select held four edges on a pulse-register write: two acks, two pulses
        nack = 0; nload = 0; npulse = 0;
        @(negedge clk);
        bus.select = 1'b1; bus.RNW = 1'b0; bus.ABus = BASE; bus.BE = 4'b1111; bus.DBus = 32'h7;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.Sl_xferAck) nack++;
            if (user_load[0]) nload++;
            if (user_data_out[31:0] == 32'h7) npulse++;
            if (i == 3) bus.select = 1'b0;
        end
        check("held_sel_acks",   256'(nack), 256'(2));
        check("held_sel_loads",  256'(nload), 256'(2));
        check("held_sel_pulses", 256'(npulse), 256'(2));

        // Randomised traffic against the model
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) user_data_in[32*k +: 32] = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 8)       ra = BASE + 32'(4 * sel);
            else if (sel == 8) ra = BASE + 32'(4 * $urandom_range(8, 63));
            else if ($urandom_range(0, 1) == 1) ra = HIGH + 1 + 32'(4 * $urandom_range(0, 4));
            else               ra = BASE - 32'(4 * $urandom_range(1, 4));
            begin
                bit          r_rnw;
                logic [0:3]  r_be;
                logic [31:0] r_d;
                r_rnw = 1'($urandom_range(0, 1));
                r_be  = 4'($urandom);
                r_d   = $urandom;
                model(r_rnw, ra, r_be, r_d, e_ack, e_rd, e_ld, e_out);
                xfer(r_rnw, ra, r_be, r_d, a_ack, a_rd, a_ld, a_out);
                check("rand_ack", 256'(a_ack), 256'(e_ack));
                if (r_rnw) check("rand_rd", 256'(a_rd), 256'(e_rd));
                check("rand_load", 256'(a_ld), 256'(e_ld));
                check("rand_out", a_out, e_out);
            end
        end

        // Reset during the ACK cycle aborts the write
        @(negedge clk);
        bus.select = 1'b1; bus.RNW = 1'b0; bus.ABus = 32'h01003804; bus.BE = 4'b1111; bus.DBus = 32'h12345678;
        @(posedge clk); #1;
        check("abort_ack_seen", 256'(bus.Sl_xferAck), 256'(1));
        bus.select = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_ack",   256'(bus.Sl_xferAck), '0);
        check("abort_load",  256'(user_load), '0);
        check("abort_word1", 256'(user_data_out[63:32]), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_load2",  256'(user_load), '0);
        check("abort_word1b", 256'(user_data_out[63:32]), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
